// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU load/store path, the debug/loader port and dataMem.
// The arbiter takes the slave modport; the environment (CPU, debug, memory) takes master.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU passes through combinationally, debug uses idle slots
// and steals one stalled CPU cycle after MAX_WAIT starved cycles.
module dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic           clk,
    input logic           rstn,
    dmem_arbiter_if.slave bus
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be in 1..15");
    end

    localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

    typedef enum logic {StNormal, StHoldoff} state_e;

    state_e        state;
    logic [3:0]    wait_cnt;
    logic          dbg_rvalid_q;
    logic [DW-1:0] dbg_rdata_q;

    logic forced_ok;
    logic gnt;
    logic cpu_act;

    always_comb begin
        forced_ok = (state == StNormal) && (wait_cnt == WaitMax);
        // Gate with rstn so nothing reaches the memory while reset is held.
        gnt       = rstn & bus.dbg_req & (~bus.cpu_req | forced_ok);
        cpu_act   = rstn & bus.cpu_req;
    end

    assign bus.dbg_gnt    = gnt;
    assign bus.cpu_stall  = gnt & bus.cpu_req;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_rdata  = dbg_rdata_q;

    always_comb begin
        if (gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dbg_we;
            bus.mem_addr  = bus.dbg_addr;
            bus.mem_wdata = bus.dbg_wdata;
        end else begin
            bus.mem_en    = cpu_act;
            bus.mem_we    = cpu_act & bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= StNormal;
            wait_cnt     <= 4'd0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            case (state)
                // A grant while the CPU is requesting is the forced (stalling) one.
                StNormal:  state <= (gnt && bus.cpu_req) ? StHoldoff : StNormal;
                StHoldoff: state <= StNormal;
                default:   state <= StNormal;
            endcase

            if (gnt || !bus.dbg_req) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != WaitMax) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            dbg_rvalid_q <= gnt & ~bus.dbg_we;
            if (gnt && !bus.dbg_we) begin
                dbg_rdata_q <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model behind it.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    logic [31:0] mem [0:63];

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.dbg_req   = req;
        bus.dbg_we    = we;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = wdata;
    endtask

    // Inputs change on the falling edge; checks happen 2 time units later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        set_cpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        set_dbg(1'b1, 1'b0, 32'h20, 32'h0);
        #2;
        chk("rst_gnt",    64'(bus.dbg_gnt),    64'd0);
        chk("rst_stall",  64'(bus.cpu_stall),  64'd0);
        chk("rst_en",     64'(bus.mem_en),     64'd0);
        chk("rst_we",     64'(bus.mem_we),     64'd0);
        chk("rst_rvalid", 64'(bus.dbg_rvalid), 64'd0);
        chk("rst_rdata",  64'(bus.dbg_rdata),  64'd0);
        step();
        step();

        // CPU store right after release passes straight through.
        rstn = 1'b1;
        set_dbg(1'b0, 1'b0, 32'h20, 32'h0);
        #2;
        chk("cpu_st_en",    64'(bus.mem_en),    64'd1);
        chk("cpu_st_we",    64'(bus.mem_we),    64'd1);
        chk("cpu_st_addr",  64'(bus.mem_addr),  64'h10);
        chk("cpu_st_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
        chk("cpu_st_stall", 64'(bus.cpu_stall), 64'd0);
        chk("cpu_st_gnt",   64'(bus.dbg_gnt),   64'd0);

        step();
        set_cpu(1'b1, 1'b1, 32'h20, 32'h12345678);
        step();
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        #2;
        chk("cpu_ld_rdata", 64'(bus.cpu_rdata), 64'hDEADBEEF);
        chk("cpu_ld_we",    64'(bus.mem_we),    64'd0);

        // Idle-slot debug read.
        step();
        set_cpu(1'b0, 1'b0, 32'h10, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h20, 32'h0);
        #2;
        chk("idle_gnt",   64'(bus.dbg_gnt),   64'd1);
        chk("idle_stall", 64'(bus.cpu_stall), 64'd0);
        chk("idle_addr",  64'(bus.mem_addr),  64'h20);
        chk("idle_en",    64'(bus.mem_en),    64'd1);
        chk("idle_we",    64'(bus.mem_we),    64'd0);
        step();
        set_dbg(1'b0, 1'b0, 32'h20, 32'h0);
        #2;
        chk("idle_rvalid", 64'(bus.dbg_rvalid), 64'd1);
        chk("idle_rdata",  64'(bus.dbg_rdata),  64'h12345678);
        chk("idle_en_off", 64'(bus.mem_en),     64'd0);
        step();
        #2;
        chk("idle_rvalid_drop", 64'(bus.dbg_rvalid), 64'd0);
        chk("idle_rdata_hold",  64'(bus.dbg_rdata),  64'h12345678);

        // Starvation: CPU busy every cycle, debug read pending.
        step();
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) step();
            #2;
            chk($sformatf("starve_cnt%0d", k),   64'(dut.wait_cnt),  64'(k));
            chk($sformatf("starve_gnt%0d", k),   64'(bus.dbg_gnt),   64'd0);
            chk($sformatf("starve_stall%0d", k), 64'(bus.cpu_stall), 64'd0);
            chk($sformatf("starve_addr%0d", k),  64'(bus.mem_addr),  64'h10);
        end
        step();
        #2;
        chk("forced_cnt",   64'(dut.wait_cnt),  64'd4);
        chk("forced_gnt",   64'(bus.dbg_gnt),   64'd1);
        chk("forced_stall", 64'(bus.cpu_stall), 64'd1);
        chk("forced_addr",  64'(bus.mem_addr),  64'h20);

        // HOLDOFF: new debug write request, CPU stores to the same word.
        step();
        set_cpu(1'b1, 1'b1, 32'h40, 32'h11111111);
        set_dbg(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5);
        #2;
        chk("hold_gnt",    64'(bus.dbg_gnt),    64'd0);
        chk("hold_stall",  64'(bus.cpu_stall),  64'd0);
        chk("hold_addr",   64'(bus.mem_addr),   64'h40);
        chk("hold_wdata",  64'(bus.mem_wdata),  64'h11111111);
        chk("hold_cnt",    64'(dut.wait_cnt),   64'd0);
        chk("hold_rvalid", 64'(bus.dbg_rvalid), 64'd1);
        chk("hold_rdata",  64'(bus.dbg_rdata),  64'h12345678);
        for (int k = 1; k < 4; k++) begin
            step();
            #2;
            chk($sformatf("rewait_cnt%0d", k), 64'(dut.wait_cnt), 64'(k));
            chk($sformatf("rewait_gnt%0d", k), 64'(bus.dbg_gnt),  64'd0);
        end
        step();
        #2;
        chk("coll_gnt",    64'(bus.dbg_gnt),    64'd1);
        chk("coll_stall",  64'(bus.cpu_stall),  64'd1);
        chk("coll_we",     64'(bus.mem_we),     64'd1);
        chk("coll_wdata",  64'(bus.mem_wdata),  64'hA5A5A5A5);
        chk("coll_addr",   64'(bus.mem_addr),   64'h40);

        // CPU retries its store after the debug write landed.
        step();
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("retry_mem",    64'(mem[16]),        64'hA5A5A5A5);
        chk("retry_rvalid", 64'(bus.dbg_rvalid), 64'd0);
        chk("retry_stall",  64'(bus.cpu_stall),  64'd0);
        chk("retry_we",     64'(bus.mem_we),     64'd1);
        chk("retry_wdata",  64'(bus.mem_wdata),  64'h11111111);
        step();
        set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        #2;
        chk("retry_ld", 64'(bus.cpu_rdata), 64'h11111111);

        // Back-to-back debug reads with the CPU idle.
        step();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h20, 32'h0);
        #2;
        chk("b2b_gnt0", 64'(bus.dbg_gnt), 64'd1);
        step();
        set_dbg(1'b1, 1'b0, 32'h10, 32'h0);
        #2;
        chk("b2b_gnt1",    64'(bus.dbg_gnt),    64'd1);
        chk("b2b_rvalid0", 64'(bus.dbg_rvalid), 64'd1);
        chk("b2b_rdata0",  64'(bus.dbg_rdata),  64'h12345678);
        step();
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("b2b_rvalid1", 64'(bus.dbg_rvalid), 64'd1);
        chk("b2b_rdata1",  64'(bus.dbg_rdata),  64'hDEADBEEF);

        // Async reset in the cycle after a forced debug read.
        step();
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) step();
        #2;
        chk("ar_forced_gnt", 64'(bus.dbg_gnt), 64'd1);
        step();
        #1;
        chk("ar_pre_rvalid", 64'(bus.dbg_rvalid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("ar_rvalid", 64'(bus.dbg_rvalid), 64'd0);
        chk("ar_gnt",    64'(bus.dbg_gnt),    64'd0);
        chk("ar_en",     64'(bus.mem_en),     64'd0);
        chk("ar_we",     64'(bus.mem_we),     64'd0);
        chk("ar_state",  64'(int'(dut.state)), 64'd0);
        chk("ar_cnt",    64'(dut.wait_cnt),   64'd0);
        step();
        rstn = 1'b1;
        #2;
        chk("ar_rel_cnt",   64'(dut.wait_cnt),  64'd0);
        chk("ar_rel_state", 64'(int'(dut.state)), 64'd0);
        chk("ar_rel_gnt",   64'(bus.dbg_gnt),   64'd0);
        chk("ar_rel_addr",  64'(bus.mem_addr),  64'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
